vga_frame_reader: RTL and testbench

Read-side display stage for the 320×240 RGB444 frame buffer. It generates 640×480@60 VGA timing from a 25 MHz pixel clock and drives the buffer's read port (`enb`/`addrb`/`doutb`, 1-cycle read latency). Each stored pixel is shown as a 2×2 block on screen. Sync outputs are delayed to stay aligned with the returned pixel data.

---
 rtl/vga_frame_reader.sv | 131 +++++++++++++
 tb/tb_vga_frame_reader.sv | 159 +++++++++++++++
 2 files changed

// File: rtl/vga_frame_reader.sv
// vga_frame_reader: 640x480@60 timing generator and read side of the
// 320x240 RGB444 frame buffer. Each stored pixel becomes a 2x2 screen block.
// Sync, RGB and frame_start all leave the block 3 clocks after the counter
// value they belong to. That covers one address register, one BRAM read
// and one output register.
module vga_frame_reader #(
  parameter int H_ACTIVE = 640,
  parameter int H_FP     = 16,
  parameter int H_SYNC   = 96,
  parameter int H_BP     = 48,
  parameter int V_ACTIVE = 480,
  parameter int V_FP     = 10,
  parameter int V_SYNC   = 2,
  parameter int V_BP     = 33
) (
  input  logic        clk,
  input  logic        rst,
  output logic        enb,
  output logic [16:0] addrb,
  input  logic [11:0] doutb,
  output logic [3:0]  vga_r,
  output logic [3:0]  vga_g,
  output logic [3:0]  vga_b,
  output logic        vga_hs,
  output logic        vga_vs,
  output logic        frame_start
);

  localparam logic [9:0] H_ACT   = 10'(H_ACTIVE);
  localparam logic [9:0] HS_BEG  = 10'(H_ACTIVE + H_FP);
  localparam logic [9:0] HS_END  = 10'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [9:0] H_MAX   = 10'(H_ACTIVE + H_FP + H_SYNC + H_BP - 1);
  localparam logic [9:0] V_ACT   = 10'(V_ACTIVE);
  localparam logic [9:0] VS_BEG  = 10'(V_ACTIVE + V_FP);
  localparam logic [9:0] VS_END  = 10'(V_ACTIVE + V_FP + V_SYNC);
  localparam logic [9:0] V_MAX   = 10'(V_ACTIVE + V_FP + V_SYNC + V_BP - 1);

  logic [9:0]  h_cnt;
  logic [9:0]  v_cnt;
  logic        active;
  logic        hs0;
  logic        vs0;
  logic        fs0;
  logic [8:0]  x;
  logic [8:0]  y;
  logic [16:0] addr;

  logic        active_d1;
  logic        hs_d1;
  logic        vs_d1;
  logic        fs_d1;
  logic        active_d2;
  logic        hs_d2;
  logic        vs_d2;
  logic        fs_d2;

  // Raster counters: h wraps every line, v advances on each h wrap.
  always_ff @(posedge clk) begin
    if (rst) begin
      h_cnt <= '0;
      v_cnt <= '0;
    end else if (h_cnt == H_MAX) begin
      h_cnt <= '0;
      v_cnt <= (v_cnt == V_MAX) ? 10'd0 : v_cnt + 10'd1;
    end else begin
      h_cnt <= h_cnt + 10'd1;
    end
  end

  // Stage 0 decode. Halving both counters gives the 2x2 duplication, and
  // y*320 is built as y*256 + y*64 so that no multiplier is needed.
  always_comb begin
    active = (h_cnt < H_ACT) && (v_cnt < V_ACT);
    hs0    = !((h_cnt >= HS_BEG) && (h_cnt < HS_END));
    vs0    = !((v_cnt >= VS_BEG) && (v_cnt < VS_END));
    fs0    = (h_cnt == 10'd0) && (v_cnt == 10'd0);
    x      = h_cnt[9:1];
    y      = v_cnt[9:1];
    addr   = {y, 8'd0} + {2'd0, y, 6'd0} + {8'd0, x};
  end

  // Stage 1: issue the read, or park the address at 0 during blanking.
  always_ff @(posedge clk) begin
    if (rst) begin
      enb       <= 1'b0;
      addrb     <= '0;
      active_d1 <= 1'b0;
      hs_d1     <= 1'b1;
      vs_d1     <= 1'b1;
      fs_d1     <= 1'b0;
    end else begin
      enb       <= active;
      addrb     <= active ? addr : 17'd0;
      active_d1 <= active;
      hs_d1     <= hs0;
      vs_d1     <= vs0;
      fs_d1     <= fs0;
    end
  end

  // Stage 2: the BRAM returns data while these delayed controls are current.
  always_ff @(posedge clk) begin
    if (rst) begin
      active_d2 <= 1'b0;
      hs_d2     <= 1'b1;
      vs_d2     <= 1'b1;
      fs_d2     <= 1'b0;
    end else begin
      active_d2 <= active_d1;
      hs_d2     <= hs_d1;
      vs_d2     <= vs_d1;
      fs_d2     <= fs_d1;
    end
  end

  // Stage 3: output registers. RGB is forced black outside the visible area.
  always_ff @(posedge clk) begin
    if (rst) begin
      {vga_r, vga_g, vga_b} <= 12'h000;
      vga_hs                <= 1'b1;
      vga_vs                <= 1'b1;
      frame_start           <= 1'b0;
    end else begin
      {vga_r, vga_g, vga_b} <= active_d2 ? doutb : 12'h000;
      vga_hs                <= hs_d2;
      vga_vs                <= vs_d2;
      frame_start           <= fs_d2;
    end
  end

endmodule

// File: tb/tb_vga_frame_reader.sv
// Testbench for vga_frame_reader. The vertical timing is shortened to 12
// lines so that several complete frames fit in a short run; the horizontal
// timing and the address arithmetic are unchanged.
module tb_vga_frame_reader;

  localparam int HA = 640, HF = 16, HS = 96, HB = 48;
  localparam int VA = 6,   VF = 2,  VS = 2,  VB = 2;
  localparam int HT = HA + HF + HS + HB;
  localparam int VT = VA + VF + VS + VB;
  localparam int FRAME = HT * VT;
  localparam logic [32:0] RST_VEC = {1'b0, 17'd0, 12'h000, 1'b1, 1'b1, 1'b0};

  logic        clk = 1'b0;
  logic        rst;
  logic        enb;
  logic [16:0] addrb;
  logic [11:0] doutb;
  logic [3:0]  vga_r, vga_g, vga_b;
  logic        vga_hs, vga_vs, frame_start;

  int          n_checks = 0;
  int          n_errors = 0;
  int          k;
  int          mode;
  int unsigned seed;
  int          hs_run, vs_run, last_fs, max_addr;

  vga_frame_reader #(
    .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
    .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB)
  ) dut (
    .clk(clk), .rst(rst), .enb(enb), .addrb(addrb), .doutb(doutb),
    .vga_r(vga_r), .vga_g(vga_g), .vga_b(vga_b),
    .vga_hs(vga_hs), .vga_vs(vga_vs), .frame_start(frame_start)
  );

  always #20 clk = ~clk;

  // Frame buffer contents: either the address itself, a constant, or a hash.
  function automatic logic [11:0] data_of(int a);
    int unsigned t;
    case (mode)
      0:       t = a;
      1:       t = 32'hABC;
      default: t = (a * seed) ^ (a >> 3);
    endcase
    return t[11:0];
  endfunction

  // BRAM with one clock of read latency; returns garbage when not enabled.
  always @(posedge clk) begin
    if (enb) doutb <= data_of(int'(addrb));
    else     doutb <= 12'($urandom);
  end

  // Expected {enb, addrb, rgb, hs, vs, fs} after the k-th clock edge since
  // reset was released, derived from the raster position of each output.
  function automatic logic [32:0] expect_at(int kk);
    logic        e, hs_e, vs_e, fs_e;
    logic [16:0] ad;
    logic [11:0] rgb;
    int          t, h, v;
    e = 1'b0; ad = '0; rgb = '0; hs_e = 1'b1; vs_e = 1'b1; fs_e = 1'b0;
    if (kk >= 1) begin
      t = (kk - 1) % FRAME; h = t % HT; v = t / HT;
      if (h < HA && v < VA) begin
        e  = 1'b1;
        ad = 17'((v / 2) * 320 + h / 2);
      end
    end
    if (kk >= 3) begin
      t = (kk - 3) % FRAME; h = t % HT; v = t / HT;
      if (h < HA && v < VA) rgb = data_of((v / 2) * 320 + h / 2);
      hs_e = !(h >= HA + HF && h < HA + HF + HS);
      vs_e = !(v >= VA + VF && v < VA + VF + VS);
      fs_e = (t == 0);
    end
    return {e, ad, rgb, hs_e, vs_e, fs_e};
  endfunction

  task automatic check_val(string tag, logic [39:0] got, logic [39:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s k=%0d got=%h exp=%h", tag, k, got, exp);
    end
  endtask

  function automatic logic [32:0] observed();
    return {enb, addrb, vga_r, vga_g, vga_b, vga_hs, vga_vs, frame_start};
  endfunction

  task automatic clear_trackers();
    k = 0; hs_run = 0; vs_run = 0; last_fs = -1;
  endtask

  task automatic run_cycles(int n);
    repeat (n) begin
      @(posedge clk);
      k++;
      @(negedge clk);
      check_val("pipe", 40'(observed()), 40'(expect_at(k)));
      if (enb && int'(addrb) > max_addr) max_addr = int'(addrb);
      if (!vga_hs) hs_run++;
      else if (hs_run > 0) begin
        check_val("hs_width", 40'(hs_run), 40'(HS));
        hs_run = 0;
      end
      if (!vga_vs) vs_run++;
      else if (vs_run > 0) begin
        check_val("vs_width", 40'(vs_run), 40'(VS * HT));
        vs_run = 0;
      end
      if (frame_start) begin
        if (last_fs >= 0) check_val("fs_period", 40'(k - last_fs), 40'(FRAME));
        last_fs = k;
      end
    end
  endtask

  // Called at a falling edge: hold reset for n edges, then release it.
  task automatic do_reset(int n, int new_mode);
    rst  = 1'b1;
    mode = new_mode;
    repeat (n) begin
      @(posedge clk);
      @(negedge clk);
      check_val("rst_vals", 40'(observed()), 40'(RST_VEC));
    end
    rst = 1'b0;
    clear_trackers();
  endtask

  initial begin
    rst = 1'b1;
    mode = 0;
    seed = $urandom | 32'd1;
    max_addr = 0;
    clear_trackers();
    @(negedge clk);
    do_reset(5, 0);

    run_cycles(2 * FRAME + 50);
    check_val("max_addr", 40'(max_addr), 40'((VA / 2 - 1) * 320 + 319));

    run_cycles(4 * HT + 300 - k % FRAME + FRAME);
    do_reset(1, 1);
    run_cycles(FRAME + 20);

    for (int r = 0; r < 4; r++) begin
      do_reset($urandom_range(1, 3), $urandom_range(0, 2));
      run_cycles($urandom_range(1000, 9000));
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
